// File: rtl/unary_pkg.sv
// Shared sizing helpers for the unary arithmetic datapath.
package unary_pkg;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int prod_width(input int n);
    return 2 * count_width(n);
  endfunction

  localparam int DEF_N      = 32;
  localparam int DEF_CW     = count_width(DEF_N);
  localparam int DEF_PROD_W = 2 * DEF_CW;

  typedef logic [DEF_CW-1:0] count_t;

endpackage

// File: rtl/unary_isqrt.sv
// Combinational floor integer square root, restoring digit-by-digit (two input bits per step).
module unary_isqrt #(
  parameter int W = 12
) (
  input  logic [W-1:0]   x,
  output logic [W/2-1:0] root
);

  localparam int H = W / 2;

  logic [W+1:0] rem;
  logic [W+1:0] trial;
  logic [H-1:0] acc;

  always_comb begin
    rem   = '0;
    trial = '0;
    acc   = '0;
    for (int i = H - 1; i >= 0; i--) begin
      rem   = {rem[W-1:0], x[2*i +: 2]};
      trial = {{H{1'b0}}, acc, 2'b01};
      if (rem >= trial) begin
        rem = rem - trial;
        acc = {acc[H-2:0], 1'b1};
      end else begin
        acc = {acc[H-2:0], 1'b0};
      end
    end
    root = acc;
  end

endmodule

// File: rtl/unary_sqrt_stream.sv
// Online square root of a rate-coded bitstream: N bits with A ones in, N bits with
// floor(sqrt(A*N)) ones out, each output bit released as soon as the bounds on A decide it.
module unary_sqrt_stream
  import unary_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = count_width(N)
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last,
  output logic busy
);

  localparam int PW = 2 * CW;

  logic [CW-1:0] in_cnt, a_ones, y_ones, y_zeros;
  logic [CW-1:0] l_bound, u_bound, n_minus_u, emitted;
  logic [PW-1:0] prod_l, prod_u;
  logic          accept, hs, close, load, cand_one, cand_zero, last_next, frame_open;

  assign prod_l = PW'(a_ones) * PW'(N);
  assign prod_u = (PW'(a_ones) + PW'(N) - PW'(in_cnt)) * PW'(N);

  unary_isqrt #(.W(PW)) u_isqrt_lo (.x(prod_l), .root(l_bound));
  unary_isqrt #(.W(PW)) u_isqrt_hi (.x(prod_u), .root(u_bound));

  assign n_minus_u  = CW'(N) - u_bound;
  assign emitted    = y_ones + y_zeros;
  assign frame_open = emitted < CW'(N);
  assign last_next  = emitted == CW'(N - 1);

  assign cand_one  = y_ones < l_bound;
  assign cand_zero = !cand_one && (y_zeros < n_minus_u);

  assign in_ready = in_cnt < CW'(N);
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid && out_ready;
  assign close    = hs && out_last;

  // The closing bit waits for the whole input frame, otherwise the tail of this
  // frame's input would be counted into the next one after the counters clear.
  assign load = (cand_one || cand_zero) && (!out_valid || hs) && frame_open &&
                (!last_next || (in_cnt == CW'(N)));

  assign busy = (in_cnt != '0) || out_valid || (emitted != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cnt  <= '0;
      a_ones  <= '0;
      y_ones  <= '0;
      y_zeros <= '0;
    end else if (close) begin
      in_cnt  <= '0;
      a_ones  <= '0;
      y_ones  <= '0;
      y_zeros <= '0;
    end else begin
      if (accept) begin
        in_cnt <= in_cnt + 1'b1;
        a_ones <= a_ones + CW'(in_bit);
      end
      if (load) begin
        if (cand_one) y_ones  <= y_ones + 1'b1;
        else          y_zeros <= y_zeros + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_bit   <= cand_one;
      out_last  <= last_next;
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_unary_sqrt_stream.sv
// Directed bench for unary_sqrt_stream: frame totals, first-bit latency, backpressure, mid-frame reset.
module tb_unary_sqrt_stream;

  localparam int N = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_bit, out_last, busy;

  int total = 0;
  int bad   = 0;
  bit inv_en = 1'b0;

  always #5 clk = ~clk;

  unary_sqrt_stream #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bit   (in_bit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bit  (out_bit),
    .out_last (out_last),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Emitted counts may never run ahead of what the bounds already guarantee.
  always @(negedge clk) begin
    if (inv_en && reset) begin
      chk("inv_ones_le_l", 32'(dut.y_ones <= dut.l_bound), 32'd1);
      chk("inv_zeros_le_n_minus_u", 32'(dut.y_zeros <= (6'(N) - dut.u_bound)), 32'd1);
    end
  end

  task automatic first_out(input logic b, input string tag);
    @(negedge clk);
    in_valid  = 1'b1;
    in_bit    = b;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_not_yet"}, out_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_bit"}, out_bit, b);
  endtask

  task automatic run_frame(input logic [31:0] pat, input int start, input int exp_ones,
                           input bit rnd, input string tag);
    int   idx;
    int   nbits;
    int   ones;
    int   cyc;
    bit   stalled;
    bit   done;
    logic pb, pl;
    idx = start; nbits = 0; ones = 0; cyc = 0;
    stalled = 1'b0; done = 1'b0; pb = 1'b0; pl = 1'b0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk({tag, "_hold_valid"}, out_valid, 1'b1);
        chk({tag, "_hold_bit"}, out_bit, pb);
        chk({tag, "_hold_last"}, out_last, pl);
      end
      if (idx < N) begin
        in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_bit   = pat[idx];
        if (in_valid && in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        chk({tag, "_last_flag"}, out_last, 32'(nbits == N - 1));
        nbits++;
        ones += int'(out_bit);
        if (out_last) done = 1'b1;
      end
      stalled = out_valid && !out_ready;
      pb = out_bit;
      pl = out_last;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_completed"}, done, 1'b1);
    chk({tag, "_bits"}, nbits, N);
    chk({tag, "_ones"}, ones, exp_ones);
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_ready_again"}, in_ready, 1'b1);
  endtask

  initial begin
    int cnt;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bit", out_bit, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    inv_en = 1'b1;

    first_out(1'b1, "ones_first");
    run_frame(32'hFFFF_FFFF, 1, 32, 1'b0, "all_ones");

    first_out(1'b0, "zeros_first");
    run_frame(32'h0000_0000, 1, 0, 1'b0, "all_zeros");

    run_frame(32'h0000_00FF, 0, 16, 1'b0, "a8");

    // back-to-back frames under random input gaps and output backpressure
    run_frame(32'h0000_0003, 0, 8, 1'b1, "a2_rnd");
    run_frame(32'h0003_FFFF, 0, 24, 1'b1, "a18_rnd");
    run_frame(32'h5A5A_1234, 0, 20, 1'b1, "a13_rnd");

    out_ready = 1'b1;
    cnt = 0;
    while (cnt < 13) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = 1'b1;
      if (in_ready) cnt++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("pre_rst_in_cnt", 32'(dut.in_cnt), 32'd13);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_out_last", out_last, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run_frame(32'hFFFF_FFFF, 0, 32, 1'b1, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
